// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   master (MEM stage): drives dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be;
//                       samples dmem_ack, dmem_rdata
//   slave  (memory)   : the mirror image
// dmem_rdata is valid in the same cycle as dmem_ack.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage. Consumes the EX/MEM register outputs, issues data-memory
// accesses over the req/ack bus, stalls upstream while an access is
// outstanding, resolves branch/jump redirect and owns the MEM/WB register.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ex_*              EX/MEM register outputs (held stable by upstream while stall=1)
//   dmem              mem_stage_if.master: data-memory request/ack bus
//   stall             freeze PC, IF/ID, ID/EX, EX/MEM
//   pc_src, pc_target fetch redirect (combinational, independent of stall)
//   wb_*              MEM/WB register outputs
//   dmem_err          sticky: access timed out or was misaligned; cleared by rst
//
// Parameter TIMEOUT (1..255): REQ cycles without dmem_ack before the access is abandoned.
// Build option SUBWORD_EN: byte/halfword loads and stores with lane selection,
// sign/zero extension and alignment checking. Undefined: every access is a full word.
//
// state | meaning
// IDLE  | no access outstanding; a memory op here stalls one cycle and moves to REQ
// REQ   | dmem_req asserted, waiting for dmem_ack or the timeout
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_pc_next,
    input  logic [31:0] ex_branch_addr,
    input  logic [31:0] ex_cal,
    input  logic [31:0] ex_rd2,
    input  logic [31:0] ex_jump_addr,
    input  logic [4:0]  ex_wn,
    input  logic [5:0]  ex_opcode,
    input  logic        ex_zero,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_branch,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_jump,
    mem_stage_if.master dmem,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_cal,
    output logic [4:0]  wb_wn,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic        dmem_err
);
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_cal_q, wb_cal_d;
    logic [4:0]  wb_wn_q, wb_wn_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic        dmem_err_q, dmem_err_d;

    logic        mem_op;
    logic        in_req;
    logic        misaligned;
    logic        ack_ok;
    logic        timeout_hit;
    logic        abort;
    logic        retire;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [31:0] load_data;

    // ex_pc_next is carried for the writeback of link values in other
    // configurations; this stage does not consume it.
    logic unused_ok;

`ifdef SUBWORD_EN
    logic        is_byte;
    logic        is_half;
    logic        is_unsigned;
    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign unused_ok = ^ex_pc_next;

    always_comb begin
        is_byte     = ex_opcode inside {6'h20, 6'h24, 6'h28};
        is_half     = ex_opcode inside {6'h21, 6'h25, 6'h29};
        is_unsigned = ex_opcode inside {6'h24, 6'h25};
        lane        = ex_cal[1:0];
        byte_sel    = dmem.dmem_rdata[{lane, 3'b000} +: 8];
        half_sel    = ex_cal[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        acc_be      = 4'b1111;
        acc_wdata   = ex_rd2;
        load_data   = dmem.dmem_rdata;
        misaligned  = 1'b0;
        if (is_byte) begin
            acc_be    = 4'b0001 << lane;
            acc_wdata = {4{ex_rd2[7:0]}};
            load_data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            acc_be     = ex_cal[1] ? 4'b1100 : 4'b0011;
            acc_wdata  = {2{ex_rd2[15:0]}};
            load_data  = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misaligned = mem_op & ex_cal[0];
        end else begin
            misaligned = mem_op & (ex_cal[1:0] != 2'b00);
        end
    end
`else
    assign unused_ok  = ^{ex_pc_next, ex_opcode};
    assign acc_be     = 4'b1111;
    assign acc_wdata  = ex_rd2;
    assign load_data  = dmem.dmem_rdata;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        mem_op      = ex_memread | ex_memwrite;
        in_req      = (state_q == REQ);
        // A misaligned access reaches REQ without ever raising dmem_req and
        // is abandoned there, giving exactly one stall cycle.
        ack_ok      = in_req & ~misaligned & dmem.dmem_ack;
        timeout_hit = in_req & ~misaligned & ~dmem.dmem_ack & (cnt_q == CNT_LAST);
        abort       = timeout_hit | (in_req & misaligned);
        retire      = (~in_req & ~mem_op) | ack_ok | abort;

        state_d       = state_q;
        cnt_d         = cnt_q;
        wb_rdata_d    = wb_rdata_q;
        wb_cal_d      = wb_cal_q;
        wb_wn_d       = wb_wn_q;
        wb_regwrite_d = 1'b0;
        wb_memtoreg_d = 1'b0;
        dmem_err_d    = dmem_err_q | abort;

        if (in_req) begin
            if (retire) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (mem_op) begin
            state_d = REQ;
            cnt_d   = 8'd0;
        end

        if (retire) begin
            wb_cal_d      = ex_cal;
            wb_wn_d       = ex_wn;
            wb_regwrite_d = ex_regwrite & ~abort;
            wb_memtoreg_d = ex_memtoreg;
        end
        if (ack_ok & ex_memread) begin
            wb_rdata_d = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            wb_rdata_q    <= 32'd0;
            wb_cal_q      <= 32'd0;
            wb_wn_q       <= 5'd0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            dmem_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_cal_q      <= wb_cal_d;
            wb_wn_q       <= wb_wn_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            dmem_err_q    <= dmem_err_d;
        end
    end

    assign stall           = ~retire;
    assign dmem.dmem_req   = in_req & ~misaligned;
    assign dmem.dmem_we    = ex_memwrite;
    assign dmem.dmem_addr  = {ex_cal[31:2], 2'b00};
    assign dmem.dmem_wdata = acc_wdata;
    assign dmem.dmem_be    = acc_be;

    assign pc_src    = ex_jump | (ex_branch & ex_zero);
    assign pc_target = ex_jump ? ex_jump_addr : ex_branch_addr;

    assign wb_rdata    = wb_rdata_q;
    assign wb_cal      = wb_cal_q;
    assign wb_wn       = wb_wn_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_memtoreg = wb_memtoreg_q;
    assign dmem_err    = dmem_err_q;
endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_pc_next, ex_branch_addr, ex_cal, ex_rd2, ex_jump_addr;
    logic [4:0]  ex_wn;
    logic [5:0]  ex_opcode;
    logic        ex_zero, ex_memread, ex_memwrite, ex_branch, ex_regwrite, ex_memtoreg, ex_jump;
    logic        stall, pc_src, wb_regwrite, wb_memtoreg, dmem_err;
    logic [31:0] pc_target, wb_rdata, wb_cal;
    logic [4:0]  wb_wn;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_pc_next(ex_pc_next), .ex_branch_addr(ex_branch_addr), .ex_cal(ex_cal),
        .ex_rd2(ex_rd2), .ex_jump_addr(ex_jump_addr), .ex_wn(ex_wn), .ex_opcode(ex_opcode),
        .ex_zero(ex_zero), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_jump(ex_jump), .dmem(bus), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
        .wb_rdata(wb_rdata), .wb_cal(wb_cal), .wb_wn(wb_wn), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] cal;
        logic [4:0]  wn;
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic        err;
        int          stall_n;
        int          req_n;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    // Present one instruction on the EX/MEM outputs and queue what it must produce.
    task automatic issue(input string nm, input logic [5:0] opc, input logic rd, input logic wr,
                         input logic [31:0] cal, input logic [31:0] rd2, input logic [4:0] wn,
                         input logic rw, input logic m2r, input logic exp_rw,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_stall,
                         input int exp_req, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata);
        exp_t e;
        ex_opcode = opc; ex_memread = rd; ex_memwrite = wr; ex_cal = cal; ex_rd2 = rd2;
        ex_wn = wn; ex_regwrite = rw; ex_memtoreg = m2r;
        ex_branch = 1'b0; ex_jump = 1'b0; ex_zero = 1'b0;
        e.name = nm; e.cal = cal; e.wn = wn; e.rw = exp_rw; e.m2r = m2r; e.rdata = exp_rdata;
        e.err = exp_err; e.stall_n = exp_stall; e.req_n = exp_req; e.we = wr; e.be = exp_be;
        e.addr = exp_addr; e.wdata = exp_wdata;
        sb.push_back(e);
    endtask

    // Clock the current instruction through until it retires; memory acks on
    // REQ cycle number ack_at (0 = never). Then pop and compare.
    task automatic run(input int ack_at, input logic [31:0] rdata);
        exp_t        e;
        int          n_stall = 0;
        int          n_req = 0;
        int          cyc = 0;
        int          bubbles = 0;
        bit          done = 0;
        logic        we_s = 1'b0;
        logic [3:0]  be_s = 4'd0;
        logic [31:0] addr_s = 32'd0;
        logic [31:0] wdata_s = 32'd0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (cyc > 0 && wb_regwrite) bubbles++;
            if (bus.dmem_req) n_req++;
            bus.dmem_ack   = bus.dmem_req && (n_req == ack_at);
            bus.dmem_rdata = rdata;
            #1;
            if (bus.dmem_req) begin
                we_s = bus.dmem_we; be_s = bus.dmem_be;
                addr_s = bus.dmem_addr; wdata_s = bus.dmem_wdata;
            end
            if (stall) n_stall++;
            else done = 1;
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({e.name, "_retired"}, 32'(done), 32'd1);
        check({e.name, "_stall_cycles"}, 32'(n_stall), 32'(e.stall_n));
        check({e.name, "_req_cycles"}, 32'(n_req), 32'(e.req_n));
        check({e.name, "_bubbles"}, 32'(bubbles), 32'd0);
        check({e.name, "_wb_cal"}, wb_cal, e.cal);
        check({e.name, "_wb_wn"}, 32'(wb_wn), 32'(e.wn));
        check({e.name, "_wb_regwrite"}, 32'(wb_regwrite), 32'(e.rw));
        check({e.name, "_wb_memtoreg"}, 32'(wb_memtoreg), 32'(e.m2r));
        check({e.name, "_wb_rdata"}, wb_rdata, e.rdata);
        check({e.name, "_dmem_err"}, 32'(dmem_err), 32'(e.err));
        if (e.req_n > 0) begin
            check({e.name, "_we"}, 32'(we_s), 32'(e.we));
            check({e.name, "_be"}, 32'(be_s), 32'(e.be));
            check({e.name, "_addr"}, addr_s, e.addr);
            check({e.name, "_wdata"}, wdata_s, e.wdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_pc_next = 32'h0000_0004; ex_branch_addr = 32'd0; ex_cal = 32'd0; ex_rd2 = 32'd0;
        ex_jump_addr = 32'd0; ex_wn = 5'd0; ex_opcode = 6'd0; ex_zero = 1'b0;
        ex_memread = 1'b0; ex_memwrite = 1'b0; ex_branch = 1'b0; ex_regwrite = 1'b0;
        ex_memtoreg = 1'b0; ex_jump = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("rst_wb_memtoreg", 32'(wb_memtoreg), 32'd0);
        check("rst_wb_cal", wb_cal, 32'd0);
        check("rst_wb_wn", 32'(wb_wn), 32'd0);
        check("rst_wb_rdata", wb_rdata, 32'd0);
        check("rst_dmem_err", 32'(dmem_err), 32'd0);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue("alu", 6'h00, 0, 0, 32'h0000_0055, 32'd0, 5'd7, 1, 0,
              1, 32'd0, 0, 0, 0, 4'hF, 32'd0, 32'd0);
        run(0, 32'd0);

        issue("lw", 6'h23, 1, 0, 32'h0000_0100, 32'd0, 5'd3, 1, 1,
              1, 32'hDEAD_BEEF, 0, 1, 1, 4'hF, 32'h0000_0100, 32'd0);
        run(1, 32'hDEAD_BEEF);

        // ack lands on the last REQ cycle before the timeout would fire
        issue("sw", 6'h2B, 0, 1, 32'h0000_0204, 32'h1234_5678, 5'd0, 0, 0,
              0, 32'hDEAD_BEEF, 0, 4, 4, 4'hF, 32'h0000_0204, 32'h1234_5678);
        run(4, 32'hCAFE_F00D);

        ex_branch = 1'b1; ex_zero = 1'b1; ex_jump = 1'b1;
        ex_branch_addr = 32'h0000_0040; ex_jump_addr = 32'h0000_0080;
        #1;
        check("pc_src_jump", 32'(pc_src), 32'd1);
        check("pc_target_jump", pc_target, 32'h0000_0080);
        ex_jump = 1'b0; ex_zero = 1'b0;
        #1;
        check("pc_src_untaken", 32'(pc_src), 32'd0);
        check("pc_target_branch", pc_target, 32'h0000_0040);
        ex_zero = 1'b1;
        #1;
        check("pc_src_taken", 32'(pc_src), 32'd1);
        ex_branch = 1'b0; ex_zero = 1'b0;

        issue("lw_timeout", 6'h23, 1, 0, 32'h0000_0300, 32'd0, 5'd4, 1, 1,
              0, 32'hDEAD_BEEF, 1, TO, TO, 4'hF, 32'h0000_0300, 32'd0);
        run(0, 32'h1111_1111);

        issue("alu_sticky", 6'h00, 0, 0, 32'h0000_0099, 32'd0, 5'd9, 1, 0,
              1, 32'hDEAD_BEEF, 1, 0, 0, 4'hF, 32'd0, 32'd0);
        run(0, 32'd0);

        // reset during the second REQ cycle abandons the access
        ex_opcode = 6'h23; ex_memread = 1'b1; ex_cal = 32'h0000_0400; ex_wn = 5'd5;
        ex_regwrite = 1'b1; ex_memtoreg = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid_req_before", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_req", 32'(bus.dmem_req), 32'd0);
        check("rst_mid_wb_regwrite", 32'(wb_regwrite), 32'd0);
        check("rst_mid_wb_memtoreg", 32'(wb_memtoreg), 32'd0);
        check("rst_mid_wb_cal", wb_cal, 32'd0);
        check("rst_mid_wb_wn", 32'(wb_wn), 32'd0);
        check("rst_mid_wb_rdata", wb_rdata, 32'd0);
        check("rst_mid_dmem_err", 32'(dmem_err), 32'd0);
        ex_memread = 1'b0;
        #1;
        check("rst_mid_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef SUBWORD_EN
        issue("lb", 6'h20, 1, 0, 32'h0000_0103, 32'd0, 5'd6, 1, 1,
              1, 32'hFFFF_FF80, 0, 1, 1, 4'b1000, 32'h0000_0100, 32'd0);
        run(1, 32'h80FF_FFFF);

        issue("lhu", 6'h25, 1, 0, 32'h0000_0102, 32'd0, 5'd8, 1, 1,
              1, 32'h0000_8001, 0, 1, 1, 4'b1100, 32'h0000_0100, 32'd0);
        run(1, 32'h8001_7FFF);

        issue("sb", 6'h28, 0, 1, 32'h0000_0102, 32'h0000_00AB, 5'd0, 0, 0,
              0, 32'h0000_8001, 0, 2, 2, 4'b0100, 32'h0000_0100, 32'hABAB_ABAB);
        run(2, 32'd0);

        issue("lh_misaligned", 6'h21, 1, 0, 32'h0000_0101, 32'd0, 5'd2, 1, 1,
              0, 32'h0000_8001, 1, 1, 0, 4'b0011, 32'h0000_0100, 32'd0);
        run(1, 32'h5555_5555);
`else
        issue("lw_lowbits", 6'h23, 1, 0, 32'h0000_0102, 32'd0, 5'd6, 1, 1,
              1, 32'hA5A5_A5A5, 0, 1, 1, 4'hF, 32'h0000_0100, 32'd0);
        run(1, 32'hA5A5_A5A5);

        issue("sw_lowbits", 6'h2B, 0, 1, 32'h0000_0203, 32'h0BAD_F00D, 5'd0, 0, 0,
              0, 32'hA5A5_A5A5, 0, 2, 2, 4'hF, 32'h0000_0200, 32'h0BAD_F00D);
        run(2, 32'd0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end
endmodule
